// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage. The NOP word is also
// used by the decode stage and the hazard unit.
package if_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    // Redirect targets are word aligned; the low two address bits are ignored.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: {pc, inst} with hold and flush. Flush dominates
// hold, and both reset and flush produce the {0, NOP} bubble.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_q;
    logic [31:0] inst_d;

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        if (flush) begin
            pc_d   = 32'd0;
            inst_d = NOP_INST;
        end else if (!hold) begin
            pc_d   = pc_in;
            inst_d = inst_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= 32'd0;
            inst_q <= NOP_INST;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign pc_out   = pc_q;
    assign inst_out = inst_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// feeds the IF/ID register, honouring decode freeze and execute redirects.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  target_q;
    logic [31:0]  target_d;
    logic [31:0]  buf_q;
    logic [31:0]  buf_d;

    logic         reg_hold;
    logic         reg_flush;
    logic [31:0]  reg_pc_in;
    logic [31:0]  reg_inst_in;
    logic [31:0]  branch_target;
    logic [31:0]  pc_next_seq;

    assign branch_target = align_word(branch_address);
    assign pc_next_seq   = pc_q + PC_STEP;

    // The address is held at pc for the whole request; pc only moves on an
    // accepting edge or when a drained redirect completes.
    assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        buf_d       = buf_q;
        reg_flush   = 1'b0;
        reg_hold    = 1'b1;
        reg_pc_in   = if_id_pc;
        reg_inst_in = NOP_INST;

        unique case (state_q)
            IDLE: begin
                state_d  = REQ;
                reg_hold = freeze;
            end

            REQ: begin
                if (branch_taken) begin
                    reg_flush = 1'b1;
                    if (imem_ready) begin
                        pc_d = branch_target;
                    end else begin
                        target_d = branch_target;
                        state_d  = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (!freeze) begin
                        reg_hold    = 1'b0;
                        reg_pc_in   = pc_next_seq;
                        reg_inst_in = imem_rdata;
                        pc_d        = pc_next_seq;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end else begin
                    reg_hold = freeze;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    reg_flush = 1'b1;
                    pc_d      = branch_target;
                    state_d   = REQ;
                end else if (!freeze) begin
                    reg_hold    = 1'b0;
                    reg_pc_in   = pc_next_seq;
                    reg_inst_in = buf_q;
                    pc_d        = pc_next_seq;
                    state_d     = REQ;
                end
            end

            DRAIN: begin
                // A redirect arriving in the same cycle as the stale word wins.
                if (branch_taken) begin
                    reg_flush = 1'b1;
                    target_d  = branch_target;
                end else begin
                    reg_hold = freeze;
                end
                if (imem_ready) begin
                    pc_d    = branch_taken ? branch_target : target_q;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            target_q <= 32'd0;
            buf_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            buf_q    <= buf_d;
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold     (reg_hold),
        .flush    (reg_flush),
        .pc_in    (reg_pc_in),
        .inst_in  (reg_inst_in),
        .pc_out   (if_id_pc),
        .inst_out (if_id_inst)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a cycle table for stream/wait/freeze, hand sequences for
// redirects, and an in-order scoreboard of words reaching IF/ID.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    int checks = 0;
    int errors = 0;

    // Memory model: ready after wait_cfg waiting cycles, or never while stalled.
    int wait_cfg = 0;
    int wait_cnt = 0;
    logic mem_stall = 1'b0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst)
    );

    always #5 clk = ~clk;

    assign imem_ready = imem_req && !mem_stall && (wait_cnt >= wait_cfg);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (imem_req && !imem_ready) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    function automatic logic [63:0] exp_word(input logic [31:0] a);
        logic [31:0] p;
        p = a + 32'd4;
        return {p, a ^ 32'hA5A5_0000};
    endfunction

    // Scoreboard of expected {if_id_pc, if_id_inst} for each new instruction.
    logic [63:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [63:0] last_seen = 64'd0;

    always begin
        @(posedge clk);
        #2;
        if (mon_en && !rst) begin
            if (if_id_inst != NOP && {if_id_pc, if_id_inst} != last_seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got pc=%h inst=%h, required none", if_id_pc, if_id_inst);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({if_id_pc, if_id_inst} !== e) begin
                        errors++;
                        $display("FAIL scoreboard_word: got pc=%h inst=%h, required pc=%h inst=%h",
                                 if_id_pc, if_id_inst, e[63:32], e[31:0]);
                    end else begin
                        $display("sb ok: pc=%h inst=%h", if_id_pc, if_id_inst);
                    end
                end
            end
            last_seen = {if_id_pc, if_id_inst};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          wc;
        logic        frz;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Row k: inputs applied before edge k, outputs expected after edge k.
        vecs[0]  = '{0, 1'b0, 1'b1, 32'h00, 32'h00, NOP};
        vecs[1]  = '{0, 1'b0, 1'b1, 32'h04, 32'h04, 32'hA5A5_0000};
        vecs[2]  = '{0, 1'b0, 1'b1, 32'h08, 32'h08, 32'hA5A5_0004};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h0C, 32'h0C, 32'hA5A5_0008};
        vecs[4]  = '{3, 1'b0, 1'b1, 32'h0C, 32'h0C, NOP};
        vecs[5]  = '{3, 1'b0, 1'b1, 32'h0C, 32'h0C, NOP};
        vecs[6]  = '{3, 1'b0, 1'b1, 32'h0C, 32'h0C, NOP};
        vecs[7]  = '{3, 1'b0, 1'b1, 32'h10, 32'h10, 32'hA5A5_000C};
        vecs[8]  = '{0, 1'b1, 1'b0, 32'h00, 32'h10, 32'hA5A5_000C};
        vecs[9]  = '{0, 1'b1, 1'b0, 32'h00, 32'h10, 32'hA5A5_000C};
        vecs[10] = '{0, 1'b0, 1'b1, 32'h14, 32'h14, 32'hA5A5_0010};

        #12;
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_pc", if_id_pc, 32'd0);
        chk("reset_inst", if_id_inst, NOP);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);

        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(exp_word(32'h00));
        exp_q.push_back(exp_word(32'h04));
        exp_q.push_back(exp_word(32'h08));
        exp_q.push_back(exp_word(32'h0C));
        exp_q.push_back(exp_word(32'h10));
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            wait_cfg = vecs[i].wc;
            freeze   = vecs[i].frz;
            cyc();
            $display("vec %0d: req=%b addr=%h pc=%h inst=%h", i, imem_req, imem_addr, if_id_pc, if_id_inst);
            chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_pc", i), if_id_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_inst", i), if_id_inst, vecs[i].exp_inst);
        end

        // Branch at the same edge as a ready word for 0x20.
        exp_q.push_back(exp_word(32'h14));
        exp_q.push_back(exp_word(32'h18));
        exp_q.push_back(exp_word(32'h1C));
        cyc(); cyc(); cyc();
        chk("pre_branch_addr", imem_addr, 32'h20);
        branch_taken = 1'b1; branch_address = 32'h100;
        cyc();
        branch_taken = 1'b0;
        $display("branch_ready: addr=%h pc=%h inst=%h", imem_addr, if_id_pc, if_id_inst);
        chk("br_ready_inst", if_id_inst, NOP);
        chk("br_ready_pc", if_id_pc, 32'd0);
        chk("br_ready_addr", imem_addr, 32'h100);
        exp_q.push_back(exp_word(32'h100));
        cyc();
        chk("target_inst", if_id_inst, 32'hA5A5_0100);

        // Branch during a wait, then a second branch while still waiting.
        mem_stall = 1'b1; branch_taken = 1'b1; branch_address = 32'h200;
        cyc();
        $display("drain1: req=%b addr=%h inst=%h", imem_req, imem_addr, if_id_inst);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr_stable1", imem_addr, 32'h104);
        chk("drain_inst", if_id_inst, NOP);
        branch_address = 32'h300;
        cyc();
        chk("drain_addr_stable2", imem_addr, 32'h104);
        branch_taken = 1'b0; mem_stall = 1'b0;
        cyc();
        $display("drain_exit: addr=%h inst=%h", imem_addr, if_id_inst);
        chk("drain_resume_addr", imem_addr, 32'h300);
        chk("drain_exit_inst", if_id_inst, NOP);
        exp_q.push_back(exp_word(32'h300));
        cyc();
        chk("latest_target_inst", if_id_inst, 32'hA5A5_0300);

        // Wrap: branch to the last word (low bits ignored), next fetch is 0.
        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFE;
        cyc();
        branch_taken = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(exp_word(32'hFFFF_FFFC));
        cyc();
        $display("wrap: addr=%h pc=%h inst=%h", imem_addr, if_id_pc, if_id_inst);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_if_id_pc", if_id_pc, 32'h0);

        // freeze and branch together: flush wins.
        freeze = 1'b1; branch_taken = 1'b1; branch_address = 32'h40;
        cyc();
        branch_taken = 1'b0;
        chk("frz_br_inst", if_id_inst, NOP);
        chk("frz_br_addr", imem_addr, 32'h40);
        cyc();
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        // Branch out of HOLD drops the buffered 0x40 word.
        branch_taken = 1'b1; branch_address = 32'h80;
        cyc();
        branch_taken = 1'b0; freeze = 1'b0;
        chk("hold_br_addr", imem_addr, 32'h80);
        chk("hold_br_inst", if_id_inst, NOP);
        exp_q.push_back(exp_word(32'h80));
        cyc();
        chk("hold_br_target_pc", if_id_pc, 32'h84);

        // Reset in the middle of an outstanding request.
        mem_stall = 1'b1;
        cyc();
        chk("midfetch_req", {31'd0, imem_req}, 32'd1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("async_reset: req=%b pc=%h inst=%h", imem_req, if_id_pc, if_id_inst);
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_pc", if_id_pc, 32'd0);
        chk("async_rst_inst", if_id_inst, NOP);
        mem_stall = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        chk("restart_addr", imem_addr, 32'h0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
